onehot_arb_mux: RTL and testbench
=================================

ONEHOT_ARB_MUX -- requirements
Module: onehot_arb_mux

Interface
REQ-001 Parameter N, default 4, number of input channels (N >= 2).
REQ-002 Parameter W, default 4, data width per channel.
REQ-003 Parameter CW, default 8, width of the select-error counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 mode  input  1  0 = round-robin arbitration, 1 = fixed one-hot select.
REQ-007 sel  input  N  one-hot channel select, used only when mode=1.
REQ-008 in_valid  input  N  per-channel data valid.
REQ-009 in_data  input  N*W  channel i occupies bits [i*W +: W].
REQ-010 in_ready  output  N  per-channel accept; combinational.
REQ-011 out_valid  output  1  out_data holds a valid word.
REQ-012 out_ready  input  1  downstream accept.
REQ-013 out_data  output  W  registered selected word.
REQ-014 out_sel  output  N  registered one-hot source of out_data.
REQ-015 sel_err_cnt  output  CW  saturating count of invalid-select cycles.

Function
REQ-016 Output stage SHALL be a single registered entry; load_en = (!out_valid | out_ready).
REQ-017 grant SHALL be a combinational N-bit vector with at most one bit set.
REQ-018 in_ready[i] SHALL equal grant[i] & load_en; transfer on channel i = in_valid[i] & in_ready[i].
REQ-019 On a transfer from channel i: out_data <= in_data[i], out_sel <= one-hot i, out_valid <= 1, next cycle (latency 1).
REQ-020 If load_en and no transfer: out_valid <= 0; out_data and out_sel SHALL hold their last values.
REQ-021 If out_valid & !out_ready: out_valid, out_data, out_sel SHALL hold unchanged, and in_ready SHALL be all zero.
REQ-022 Simultaneous out_ready and new transfer SHALL replace the entry in the same edge, with out_valid staying 1 (no bubble).
REQ-023 mode=0: grant SHALL go to the first channel with in_valid set, searching from pointer ptr upward and wrapping from N-1 to 0.
REQ-024 ptr SHALL be an internal index, 0..N-1; after a transfer from channel i, ptr <= (i+1) mod N; otherwise ptr holds.
REQ-025 mode=1 with sel exactly one-hot: grant = sel & in_valid; ptr SHALL not change.
REQ-026 mode=1 with sel zero or multi-hot: grant SHALL be all zero; sel_err_cnt SHALL increment by 1 that cycle.
REQ-027 sel_err_cnt SHALL saturate at 2^CW-1 and never wrap.
REQ-028 mode and sel SHALL be used combinationally in the same cycle; a mode change does not flush the output entry.
REQ-029 sel SHALL be ignored when mode=0 and SHALL not affect sel_err_cnt.

Reset
REQ-030 When rst=1 at a clock edge, the following values SHALL be loaded: out_valid=0, out_data=0, out_sel=0, ptr=0, sel_err_cnt=0.
REQ-031 in_ready SHALL be all zero in any cycle where rst=1.
REQ-032 Reset asserted while out_valid=1 and out_ready=0 SHALL discard the held word; no transfer completes in that cycle.

Verification
REQ-033 Reset then mode=0, in_valid=4'b1111, in_data={4'hD,4'hC,4'hB,4'hA}, out_ready=1 for 4 cycles -> out_data A,B,C,D on consecutive cycles; out_sel 0001,0010,0100,1000; out_valid=1 from cycle 2.
REQ-034 mode=0, ptr=2, in_valid=4'b0011 -> grant channel 0 (wrap); ptr becomes 1; next grant channel 1.
REQ-035 Entry valid, out_ready=0 for 3 cycles, in_valid=4'b0001 -> out_data stable, in_ready=0; first cycle out_ready=1 -> in_ready[0]=1; new word appears next cycle with no bubble.
REQ-036 mode=1, sel=4'b0100, in_valid=4'b1111 -> only channel 2 transfers, repeatedly; ptr unchanged.
REQ-037 mode=1, sel=4'b0110 for 300 cycles, CW=8 -> no transfers, out_valid drops to 0 after the held word is accepted, sel_err_cnt=255 (saturated).
REQ-038 rst pulse mid-stream with out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, out_sel=0, sel_err_cnt=0; round-robin restarts at channel 0.

Source files
------------

// File: rtl/onehot_arb_mux.sv
// onehot_arb_mux
//   N-channel valid/ready multiplexer with a single registered output entry.
//   mode=0: round-robin arbitration starting at an internal pointer.
//   mode=1: fixed one-hot select. A zero or multi-hot select grants nothing
//           and bumps a saturating error counter.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   mode, sel    : arbitration mode and one-hot select (sel used only when mode=1)
//   in_valid     : per-channel valid
//   in_data      : channel i at [i*W +: W]
//   in_ready     : per-channel accept (combinational)
//   out_valid    : out_data holds a valid word
//   out_ready    : downstream accept
//   out_data     : registered selected word
//   out_sel      : registered one-hot source of out_data
//   sel_err_cnt  : saturating count of invalid-select cycles
module onehot_arb_mux #(
  parameter int N  = 4,
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [N-1:0]   sel,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [N-1:0]   out_sel,
  output logic [CW-1:0]  sel_err_cnt
);

  localparam int          PW = $clog2(N);
  localparam int unsigned NU = N;

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] nptr;
  logic          found;
  logic          sel_ok;
  logic          load_en;
  logic [N-1:0]  grant;
  logic [N-1:0]  xfer;
  logic [W-1:0]  xdata;

  assign load_en = !out_valid || out_ready;
  assign sel_ok  = $onehot(sel);

  // Grant: at most one bit. Round-robin scans channels ptr, ptr+1, ... wrapping.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    if (mode) begin
      if (sel_ok) grant = sel & in_valid;
    end else begin
      for (int unsigned k = 0; k < NU; k++) begin
        idx = PW'((32'(ptr) + k) % NU);
        if (!found && in_valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  assign in_ready = rst ? '0 : (grant & {N{load_en}});
  assign xfer     = in_valid & in_ready;

  // xfer is one-hot or zero, so at most one iteration matches.
  always_comb begin
    xdata = '0;
    nptr  = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (xfer[i]) begin
        xdata = in_data[i*W +: W];
        nptr  = PW'((i + 1) % NU);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sel     <= '0;
      ptr         <= '0;
      sel_err_cnt <= '0;
    end else begin
      if (load_en) begin
        if (|xfer) begin
          out_valid <= 1'b1;
          out_data  <= xdata;
          out_sel   <= xfer;
          // Fixed-select transfers leave the round-robin pointer alone.
          if (!mode) ptr <= nptr;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (mode && !sel_ok && (sel_err_cnt != '1))
        sel_err_cnt <= sel_err_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_onehot_arb_mux.sv
module tb_onehot_arb_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [3:0]  sel;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [3:0]  out_sel;
  logic [7:0]  sel_err_cnt;

  int vectors    = 0;
  int miscompares = 0;

  // Reference state
  logic       m_valid;
  logic [3:0] m_data;
  logic [3:0] m_sel;
  int         m_ptr;
  int         m_err;

  onehot_arb_mux #(.N(4), .W(4), .CW(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .sel_err_cnt(sel_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin: lowest valid channel at or above ptr, else lowest valid overall.
  function automatic logic [3:0] model_grant(input logic md, input logic [3:0] s,
                                             input logic [3:0] iv, input int p);
    int unsigned v, hi, pick;
    if (md) return ($countones(s) == 1) ? (s & iv) : 4'b0;
    v    = iv;
    hi   = v & ~((32'd1 << p) - 1);
    pick = (hi != 0) ? hi : v;
    return 4'(pick & (~pick + 1));
  endfunction

  task automatic step(input logic r, input logic md, input logic [3:0] s,
                      input logic [3:0] iv, input logic [15:0] id, input logic ordy);
    logic [3:0] g;
    logic       le;
    int         ch;
    rst = r; mode = md; sel = s; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    le = !m_valid || ordy;
    g  = model_grant(md, s, iv, m_ptr);
    check("in_ready", 32'(in_ready), 32'((r || !le) ? 4'b0 : g));
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_data = '0; m_sel = '0; m_ptr = 0; m_err = 0;
    end else begin
      if (le) begin
        if (g != 0) begin
          ch      = $clog2(g);
          m_valid = 1'b1;
          m_data  = 4'((id >> (ch * 4)) & 16'hF);
          m_sel   = g;
          if (!md) m_ptr = (ch + 1) % 4;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (md && ($countones(s) != 1) && (m_err < 255)) m_err++;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_sel", 32'(out_sel), 32'(m_sel));
    check("sel_err_cnt", 32'(sel_err_cnt), 32'(m_err));
  endtask

  initial begin
    m_valid = 1'b0; m_data = '0; m_sel = '0; m_ptr = 0; m_err = 0;

    // Reset state
    step(1, 0, 4'h0, 4'h0, 16'h0, 1);
    step(1, 0, 4'hF, 4'hF, 16'h1234, 0);

    // Round-robin over all four channels: A,B,C,D
    step(0, 0, 4'h0, 4'hF, 16'hDCBA, 1);
    check("rr_first_word", 32'(out_data), 32'hA);
    check("rr_first_sel", 32'(out_sel), 32'h1);
    step(0, 0, 4'h0, 4'hF, 16'hDCBA, 1);
    step(0, 0, 4'h0, 4'hF, 16'hDCBA, 1);
    step(0, 0, 4'h0, 4'hF, 16'hDCBA, 1);
    check("rr_last_sel", 32'(out_sel), 32'h8);

    // Pointer wrap: move ptr to 2, then only channels 0/1 valid
    step(0, 0, 4'hF, 4'b0010, 16'h5678, 1);
    step(0, 0, 4'h0, 4'b0011, 16'h9A21, 1);
    check("wrap_sel", 32'(out_sel), 32'h1);
    step(0, 0, 4'h0, 4'b0011, 16'h9A43, 1);
    check("wrap_next_sel", 32'(out_sel), 32'h2);

    // Backpressure hold, then replace without a bubble
    step(0, 0, 4'h0, 4'b0001, 16'h0005, 1);
    step(0, 0, 4'h0, 4'b0001, 16'h0006, 0);
    step(0, 0, 4'h0, 4'b0001, 16'h0007, 0);
    step(0, 0, 4'h0, 4'b0001, 16'h0008, 0);
    step(0, 0, 4'h0, 4'b0001, 16'h0009, 1);
    check("nobubble_data", 32'(out_data), 32'h9);

    // Fixed select on channel 2
    for (int i = 0; i < 5; i++) step(0, 1, 4'b0100, 4'hF, 16'($urandom), 1);
    // Round-robin resumes from the pointer left by the last mode=0 transfer (1)
    step(0, 0, 4'b0110, 4'hF, 16'h4321, 1);
    check("ptr_kept_sel", 32'(out_sel), 32'h2);

    // Invalid multi-hot select: no transfers, counter saturates
    for (int i = 0; i < 300; i++) step(0, 1, 4'b0110, 4'hF, 16'($urandom), 1);
    check("err_saturated", 32'(sel_err_cnt), 32'd255);

    // Reset while the entry is held under backpressure
    step(0, 0, 4'h0, 4'hF, 16'hBEEF, 1);
    step(0, 0, 4'h0, 4'hF, 16'hBEEF, 0);
    step(1, 0, 4'h0, 4'hF, 16'hBEEF, 0);
    step(0, 0, 4'h0, 4'hF, 16'hCAFE, 1);
    check("post_reset_sel", 32'(out_sel), 32'h1);

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 2) == 0) ? 4'($urandom) : (4'b1 << $urandom_range(0, 3));
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0), s,
           4'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
